digit_scan: RTL and testbench

Time-multiplexed scan controller that sits directly upstream of the 3-to-8 `decoder`. It steps a 3-bit digit select through `NUM_DIGITS` positions and drives the decoder's `data_in` and `ena` inputs. It inserts a one-cycle guard gap between digits to prevent ghosting, and presents the 4-bit value for the active digit to the segment path. It pulses a frame marker once per complete scan.

---
 rtl/digit_scan_if.sv | 21 ++
 rtl/digit_scan.sv | 110 +++++++++++
 tb/tb_digit_scan.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/digit_scan_if.sv
// Scan-controller bus: run/digit/blank inputs toward the scanner, select/enable/nibble/frame outputs from it.
// Pure wiring bundle; the master drives run, digits and blank_mask and the slave drives the rest.
interface digit_scan_if;
    logic        run;
    logic [31:0] digits;
    logic [7:0]  blank_mask;
    logic [2:0]  sel;
    logic        ena;
    logic [3:0]  nibble;
    logic        frame_done;

    modport master (
        output run, digits, blank_mask,
        input  sel, ena, nibble, frame_done
    );

    modport slave (
        input  run, digits, blank_mask,
        output sel, ena, nibble, frame_done
    );
endinterface

// File: rtl/digit_scan.sv
// Purpose: time-multiplexed digit scanner feeding a 3-to-8 decoder, with a one-cycle guard gap per digit.
// Latency: registered outputs; GUARD follows the edge that samples run=1; each digit lasts DIVIDER+1 cycles.
// Backpressure: none; run is only honoured in IDLE and at the end of each digit's dwell.
module digit_scan #(
    parameter int DIVIDER    = 4,
    parameter int NUM_DIGITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    digit_scan_if.slave  bus
);
    localparam int              CW         = $clog2(DIVIDER) + 1;
    localparam logic [2:0]      LAST_SEL   = 3'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]   LAST_DWELL = CW'(DIVIDER - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic          ena_q, ena_d;
    logic [3:0]    nibble_q, nibble_d;
    logic          frame_done_q, frame_done_d;
    logic          blank_q, blank_d;
    logic [CW-1:0] dwell_q, dwell_d;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ena_d        = ena_q;
        nibble_d     = nibble_q;
        frame_done_d = 1'b0;
        blank_d      = blank_q;
        dwell_d      = dwell_q;

        case (state_q)
            IDLE: begin
                ena_d = 1'b0;
                sel_d = 3'd0;
                if (bus.run) begin
                    state_d = GUARD;
                end
            end
            GUARD: begin
                state_d  = SHOW;
                dwell_d  = '0;
                blank_d  = bus.blank_mask[sel_q];
                ena_d    = ~bus.blank_mask[sel_q];
                nibble_d = bus.digits[{sel_q, 2'b00} +: 4];
            end
            SHOW: begin
                if (dwell_q == LAST_DWELL) begin
                    ena_d = 1'b0;
                    if (sel_q == LAST_SEL) begin
                        sel_d        = 3'd0;
                        frame_done_d = 1'b1;
                        state_d      = bus.run ? GUARD : IDLE;
                    end else if (bus.run) begin
                        sel_d   = sel_q + 3'd1;
                        state_d = GUARD;
                    end else begin
                        sel_d   = 3'd0;
                        state_d = IDLE;
                    end
                end else begin
                    ena_d   = ~blank_q;
                    dwell_d = dwell_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ena_d   = 1'b0;
                sel_d   = 3'd0;
            end
        endcase

        // Preload the nibble on entry to GUARD so the guard cycle already shows the new digit.
        if ((state_d == GUARD) && (state_q != GUARD)) begin
            nibble_d = bus.digits[{sel_d, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 3'd0;
            ena_q        <= 1'b0;
            nibble_q     <= 4'd0;
            frame_done_q <= 1'b0;
            blank_q      <= 1'b0;
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ena_q        <= ena_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
            blank_q      <= blank_d;
            dwell_q      <= dwell_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.ena        = ena_q;
    assign bus.nibble     = nibble_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_digit_scan.sv
// Bench for digit_scan: an 8-digit/DIVIDER=4 instance and a 3-digit/DIVIDER=1 instance.
// Expected outputs are queued per cycle as stimulus is driven and compared on the falling edge.
module tb_digit_scan;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    digit_scan_if ifa ();
    digit_scan_if ifb ();

    digit_scan #(.DIVIDER(4), .NUM_DIGITS(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    digit_scan #(.DIVIDER(1), .NUM_DIGITS(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        int         cyc;
        int         which;
        string      tag;
        logic [2:0] sel;
        logic       ena;
        logic [3:0] nib;
        logic       nchk;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    logic [8:0] got_v;
    logic [8:0] exp_v;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc_cnt, got, exp);
        end
    endtask

    // Compare every queued expectation that falls due this cycle; vector is {sel, ena, nibble, frame_done}.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            cur = sb.pop_front();
            if (cur.which == 0)
                got_v = {ifa.sel, ifa.ena, ifa.nibble & {4{cur.nchk}}, ifa.frame_done};
            else
                got_v = {ifb.sel, ifb.ena, ifb.nibble & {4{cur.nchk}}, ifb.frame_done};
            exp_v = {cur.sel, cur.ena, cur.nib & {4{cur.nchk}}, cur.fd};
            chk(cur.tag, {23'd0, got_v}, {23'd0, exp_v});
        end
    end

    task automatic push(input int which, input string tag, input logic [2:0] s, input logic e,
                        input logic [3:0] n, input logic nc, input logic f);
        exp_t x;
        x.cyc   = cyc_cnt + 1;
        x.which = which;
        x.tag   = tag;
        x.sel   = s;
        x.ena   = e;
        x.nib   = n;
        x.nchk  = nc;
        x.fd    = f;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int which, input string tag, input logic [2:0] s, input logic e,
                        input logic [3:0] n, input logic nc, input logic f);
        push(which, tag, s, e, n, nc, f);
        tick();
    endtask

    function automatic logic [3:0] nib_of(input int which, input int k);
        logic [31:0] d;
        d = (which == 0) ? ifa.digits : ifb.digits;
        return d[4*k +: 4];
    endfunction

    // One digit as seen on the outputs: a guard cycle then div show cycles.
    task automatic digit(input int which, input int k, input int div, input bit blanked, input bit fd);
        logic [3:0] n;
        n = nib_of(which, k);
        step(which, (which == 0) ? "a_guard" : "b_guard", 3'(k), 1'b0, n, 1'b1, fd);
        for (int i = 0; i < div; i++)
            step(which, (which == 0) ? "a_show" : "b_show", 3'(k), ~blanked, n, 1'b1, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        ifa.run        = 1'b0;
        ifa.digits     = 32'h7654_3210;
        ifa.blank_mask = 8'h00;
        ifb.run        = 1'b0;
        ifb.digits     = 32'h0000_0CBA;
        ifb.blank_mask = 8'h00;

        // Reset then idle with run low.
        for (int i = 0; i < 2; i++) begin
            push(1, "b_rst", 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);
            step(0, "a_rst", 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++)
            step(0, "a_idle", 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);

        // Full scan, no blanking.
        ifa.run = 1'b1;
        for (int k = 0; k < 8; k++)
            digit(0, k, 4, 1'b0, 1'b0);

        // Second frame: digit 2 blanked, mask flipped mid-show of digit 5.
        ifa.blank_mask = 8'b0000_0100;
        for (int k = 0; k < 5; k++)
            digit(0, k, 4, (k == 2), (k == 0));
        step(0, "a_guard5", 3'd5, 1'b0, 4'd5, 1'b1, 1'b0);
        step(0, "a_show5", 3'd5, 1'b1, 4'd5, 1'b1, 1'b0);
        ifa.blank_mask = 8'b0010_0000;
        for (int i = 0; i < 3; i++)
            step(0, "a_blank_hold", 3'd5, 1'b1, 4'd5, 1'b1, 1'b0);
        digit(0, 6, 4, 1'b0, 1'b0);
        digit(0, 7, 4, 1'b0, 1'b0);

        // Third frame: run dropped during digit 3's second show cycle.
        ifa.blank_mask = 8'h00;
        for (int k = 0; k < 3; k++)
            digit(0, k, 4, 1'b0, (k == 0));
        step(0, "a_guard3", 3'd3, 1'b0, 4'd3, 1'b1, 1'b0);
        step(0, "a_show3", 3'd3, 1'b1, 4'd3, 1'b1, 1'b0);
        ifa.run = 1'b0;
        for (int i = 0; i < 3; i++)
            step(0, "a_drop_show", 3'd3, 1'b1, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(0, "a_drop_idle", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Restart with a new pattern, then reset during digit 6 show.
        ifa.digits = 32'hFEDC_BA98;
        ifa.run    = 1'b1;
        for (int k = 0; k < 6; k++)
            digit(0, k, 4, 1'b0, 1'b0);
        step(0, "a_guard6", 3'd6, 1'b0, 4'hE, 1'b1, 1'b0);
        step(0, "a_show6", 3'd6, 1'b1, 4'hE, 1'b1, 1'b0);
        step(0, "a_show6", 3'd6, 1'b1, 4'hE, 1'b1, 1'b0);
        rst = 1'b1;
        push(1, "b_rst_mid", 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        step(0, "a_rst_mid", 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        rst = 1'b0;
        step(0, "a_rst_guard", 3'd0, 1'b0, 4'h8, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            step(0, "a_rst_show", 3'd0, 1'b1, 4'h8, 1'b1, 1'b0);
        ifa.run = 1'b0;
        for (int i = 0; i < 3; i++)
            step(0, "a_post_idle", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Short configuration: 3 digits, single show cycle each.
        ifb.run = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 3; k++)
                digit(1, k, 1, 1'b0, (k == 0) && (f > 0));
        ifb.run = 1'b0;
        step(1, "b_end_fd", 3'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1, "b_idle", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1, "b_idle", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        tick();
        tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
